// File: rtl/seg7_scan_display.sv
// Rolling DIGITS-deep pattern buffer fed by a valid/ready port, scanned onto a
// common-segment display with one-hot anodes and a blank gap at each slot start.
module seg7_scan_display #(
    parameter int DIGITS         = 4,
    parameter int REFRESH_DIV    = 1000,
    parameter int BLANK_CYCLES   = 100,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_seg,
    input  logic              clear,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg,
    output logic              frame_start
);

    localparam int DIV_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W  = $clog2(DIGITS);
    localparam int FILL_W = $clog2(DIGITS + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIV_W-1:0]  BLANK_END = DIV_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(DIGITS);
    localparam logic [6:0]        SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } state_t;

    localparam state_t STATE_INIT = (BLANK_CYCLES > 0) ? BLANK : ON;

    state_t state_q;
    state_t state_nxt;

    logic [DIV_W-1:0]  div;
    logic [DIV_W-1:0]  div_nxt;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nxt;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_nxt;
    logic [6:0]        digit_buf     [DIGITS];
    logic [6:0]        digit_buf_nxt [DIGITS];
    logic              ready_q;
    logic              xfer;
    logic [DIGITS-1:0] an_nxt;
    logic [6:0]        seg_nxt;

    // Clear overrides the handshake so a write offered alongside it is refused.
    assign in_ready    = ready_q & ~rst & ~clear;
    assign xfer        = in_valid & in_ready;
    assign frame_start = ~rst & (div == '0) & (idx == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STATE_INIT;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        digit_buf_nxt = digit_buf;
        fill_nxt      = fill;
        if (clear) begin
            for (int k = 0; k < DIGITS; k++) begin
                digit_buf_nxt[k] = '0;
            end
            fill_nxt = '0;
        end else if (xfer) begin
            for (int k = DIGITS - 1; k > 0; k--) begin
                digit_buf_nxt[k] = digit_buf[k-1];
            end
            digit_buf_nxt[0] = in_seg;
            if (fill != FILL_MAX) begin
                fill_nxt = fill + FILL_W'(1);
            end
        end
    end

    always_comb begin
        div_nxt = div + DIV_W'(1);
        idx_nxt = idx;
        if (div == DIV_LAST) begin
            div_nxt = '0;
            idx_nxt = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end

        state_nxt = state_q;
        case (state_q)
            BLANK: if (div_nxt == BLANK_END) state_nxt = ON;
            ON:    if ((div_nxt == '0) && (BLANK_CYCLES > 0)) state_nxt = BLANK;
            default: state_nxt = STATE_INIT;
        endcase

        // Outputs are decoded from next-cycle state so the registered drive
        // lines up with the div/idx of the cycle it is displayed in.
        an_nxt  = '0;
        seg_nxt = SEG_OFF;
        if (state_nxt == ON) begin
            an_nxt = {{(DIGITS-1){1'b0}}, 1'b1} << idx_nxt;
            if (FILL_W'(idx_nxt) < fill_nxt) begin
                seg_nxt = digit_buf_nxt[idx_nxt] ^ SEG_OFF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div     <= '0;
            idx     <= '0;
            fill    <= '0;
            ready_q <= 1'b0;
            an      <= '0;
            seg     <= SEG_OFF;
            for (int k = 0; k < DIGITS; k++) begin
                digit_buf[k] <= '0;
            end
        end else begin
            div       <= div_nxt;
            idx       <= idx_nxt;
            fill      <= fill_nxt;
            ready_q   <= 1'b1;
            an        <= an_nxt;
            seg       <= seg_nxt;
            digit_buf <= digit_buf_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: active-high and active-low instances
// driven in parallel, with per-cycle expectations queued by the stimulus.
module tb_seg7_scan_display;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       clear;
    logic [6:0] in_seg;

    logic       in_ready, in_ready_lo;
    logic       frame_start, frame_start_lo;
    logic [3:0] an, an_lo;
    logic [6:0] seg, seg_lo;

    always #5 clk = ~clk;

    seg7_scan_display #(
        .DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b0)
    ) u_hi (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_seg(in_seg), .clear(clear), .an(an), .seg(seg), .frame_start(frame_start)
    );

    seg7_scan_display #(
        .DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b1)
    ) u_lo (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_lo),
        .in_seg(in_seg), .clear(clear), .an(an_lo), .seg(seg_lo), .frame_start(frame_start_lo)
    );

    typedef struct packed {
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        fs;
        logic        rdy;
        logic        hchk;
        logic [6:0]  hseg;
        logic [31:0] t;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state: cycle number since reset, fill level and buffer contents.
    int         t;
    int         fill;
    logic [6:0] mb [4];
    logic       rq;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req, input logic [31:0] cyc);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, req);
        end
    endtask

    task automatic model_reset();
        t    = 0;
        fill = 0;
        rq   = 1'b0;
        for (int k = 0; k < 4; k++) mb[k] = 7'd0;
    endtask

    task automatic cycle(input logic v, input logic [6:0] s, input logic clr,
                         input logic r, input logic hc = 1'b0,
                         input logic [6:0] hs = 7'd0);
        exp_t e;
        int   ph, slot, d;
        logic rdy;
        rst      = r;
        in_valid = v;
        in_seg   = s;
        clear    = clr;
        ph   = t % 32;
        slot = ph / 8;
        d    = ph % 8;
        rdy  = rq && !r && !clr;
        e.an   = (d >= 2) ? 4'(1 << slot) : 4'd0;
        e.seg  = ((d >= 2) && (slot < fill)) ? mb[slot] : 7'd0;
        e.fs   = (ph == 0) && !r;
        e.rdy  = rdy;
        e.hchk = hc;
        e.hseg = hs;
        e.t    = t;
        q.push_back(e);
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            t++;
            rq = 1'b1;
            if (clr) begin
                for (int k = 0; k < 4; k++) mb[k] = 7'd0;
                fill = 0;
            end else if (v && rdy) begin
                for (int k = 3; k > 0; k--) mb[k] = mb[k-1];
                mb[0] = s;
                if (fill < 4) fill++;
            end
        end
        #1;
    endtask

    task automatic idle_until(input int tt);
        while (t < tt) cycle(1'b0, 7'd0, 1'b0, 1'b0);
    endtask

    task automatic hand(input logic [6:0] hs);
        cycle(1'b0, 7'd0, 1'b0, 1'b0, 1'b1, hs);
    endtask

    initial begin : monitor
        exp_t       e;
        logic [6:0] inv;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                inv = ~e.seg;
                check("an",          32'(an),             32'(e.an),  e.t);
                check("seg",         32'(seg),            32'(e.seg), e.t);
                check("frame_start", 32'(frame_start),    32'(e.fs),  e.t);
                check("in_ready",    32'(in_ready),       32'(e.rdy), e.t);
                check("an_lo",       32'(an_lo),          32'(e.an),  e.t);
                check("seg_lo",      32'(seg_lo),         32'(inv),   e.t);
                check("frame_lo",    32'(frame_start_lo), 32'(e.fs),  e.t);
                check("ready_lo",    32'(in_ready_lo),    32'(e.rdy), e.t);
                if (e.hchk) begin
                    inv = ~e.hseg;
                    check("seg_hand",    32'(seg),    32'(e.hseg), e.t);
                    check("seg_lo_hand", 32'(seg_lo), 32'(inv),    e.t);
                end
            end
        end
    end

    initial begin : stimulus
        rst      = 1'b1;
        in_valid = 1'b0;
        clear    = 1'b0;
        in_seg   = 7'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single write of "1" into digit 0 while it is lit.
        idle_until(3);
        cycle(1'b1, 7'b0110000, 1'b0, 1'b0);
        repeat (4) hand(7'b0110000);
        idle_until(34);
        hand(7'b0110000);

        // Rolling writes "0".."4" during the digit-0 slot; each shows next cycle.
        cycle(1'b1, 7'b1111110, 1'b0, 1'b0, 1'b1, 7'b0110000);
        cycle(1'b1, 7'b0110000, 1'b0, 1'b0, 1'b1, 7'b1111110);
        cycle(1'b1, 7'b1101101, 1'b0, 1'b0, 1'b1, 7'b0110000);
        cycle(1'b1, 7'b1111001, 1'b0, 1'b0, 1'b1, 7'b1101101);
        cycle(1'b1, 7'b0110011, 1'b0, 1'b0, 1'b1, 7'b1111001);
        idle_until(66); hand(7'b0110011);
        idle_until(74); hand(7'b1111001);
        idle_until(82); hand(7'b1101101);
        idle_until(90); hand(7'b0110000);

        // Clear and write together: clear wins, everything goes dark.
        idle_until(100);
        cycle(1'b1, 7'h7F, 1'b1, 1'b0);
        idle_until(130); hand(7'd0);
        idle_until(138); hand(7'd0);
        idle_until(146); hand(7'd0);
        idle_until(154); hand(7'd0);

        // Three writes, then a one-cycle reset at idx=2, div=5.
        idle_until(163);
        cycle(1'b1, 7'b1101101, 1'b0, 1'b0);
        cycle(1'b1, 7'b1111001, 1'b0, 1'b0);
        cycle(1'b1, 7'b0110011, 1'b0, 1'b0);
        idle_until(181);
        cycle(1'b0, 7'd0, 1'b0, 1'b1);
        idle_until(2);
        repeat (6) hand(7'd0);
        idle_until(40);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Downstream stage of the instruction decoder/ALU, which produces one 7-bit seven-segment pattern per executed instruction.
- Captures each pattern through a valid/ready handshake into a DIGITS-deep rolling buffer; the newest pattern is digit 0, older ones shift toward digit DIGITS-1.
- Time-multiplexes the buffer onto a common-segment display: one-hot anode select, programmable refresh period, and an anti-ghosting blank gap between digits.

Parameters:
- DIGITS, 4, number of display digits / buffer entries; must be >= 2.
- REFRESH_DIV, 1000, clock cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 100, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.
- SEG_ACTIVE_LOW, 0, 1 inverts the seg output polarity (anodes are unaffected).

Ports:
- clk  input  1  rising-edge clock, single domain.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  a pattern is offered on in_seg.
- in_ready  output  1  the block accepts; a transfer occurs on a cycle with in_valid & in_ready.
- in_seg  input  7  segment pattern, bit6=a … bit0=g, active-high (7'b1111110 = "0").
- clear  input  1  empties the buffer.
- an  output  DIGITS  one-hot digit enable, active-high; all zero during the blank gap.
- seg  output  7  segment drive for the selected digit, polarity per SEG_ACTIVE_LOW.
- frame_start  output  1  one-cycle pulse at the first cycle of the digit-0 slot.

Behaviour:
- Reset (rst=1 at an edge) clears the following:
  - buffer to 7'b0, fill count to 0, digit index to 0, slot counter to 0;
  - an=0 and seg=off (7'b0, or 7'h7F if SEG_ACTIVE_LOW);
  - in_ready=0 and frame_start=0.
- Reset mid-scan or mid-transfer aborts all activity; no partial update survives.
- in_ready = 1 whenever rst=0 and clear=0 (registered: it rises the cycle after rst deasserts). There is no back-pressure otherwise, and a transfer completes in one cycle.
- Transfer: buf[k] <= buf[k-1] for k=DIGITS-1..1, and buf[0] <= in_seg.
  - fill <= min(fill+1, DIGITS).
  - On overflow the oldest entry (buf[DIGITS-1]) is discarded silently.
- clear=1: the buffer is zeroed and fill <= 0 at the next edge. in_ready is low that cycle, so a simultaneous in_valid is not accepted (clear wins).
- The scan keeps running through clear; it is not reset by it.
- Scan FSM has two states, BLANK and ON.
  - The slot counter div runs 0..REFRESH_DIV-1.
  - State is BLANK while div < BLANK_CYCLES and ON otherwise.
  - When div = REFRESH_DIV-1, div wraps to 0 and idx <= (idx+1) mod DIGITS.
- Outputs are registered and reflect the div/idx value of the same cycle:
  - BLANK: an=0, seg=off.
  - ON: an = 1<<idx. seg = buf[idx] if idx < fill, else off (unfilled digits are dark).
- A write during ON is visible on seg one cycle after the accepting edge; no tearing within a cycle.
- frame_start=1 exactly when idx=0 and div=0.
  - First pulse: the first cycle after rst deasserts.
  - Period: DIGITS*REFRESH_DIV cycles.
- Timing, with cycle 0 = first cycle after rst deassert:
  - Digit i is lit during cycles i*REFRESH_DIV+BLANK_CYCLES .. (i+1)*REFRESH_DIV-1, modulo the frame.
- Widths:
  - div is clog2(REFRESH_DIV) bits, idx is clog2(DIGITS) bits, fill is clog2(DIGITS+1) bits.
  - Counters wrap only at their defined terminal values, never at the power of two.

Test Plan:
Configuration for all tests: DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, SEG_ACTIVE_LOW=0.
- Reset/scan: release rst with no writes → in_ready=1 from cycle 1; frame_start at cycles 0, 32, 64.
  - an=0 in cycles 0-1; an=4'b0001 in cycles 2-7; an=4'b0010 in cycles 10-15.
  - seg=0 throughout (fill=0).
- Single write: push 7'b0110000 ("1") in cycle 3 → seg=7'b0110000 from cycle 4 through cycle 7.
  - Digits 1-3 stay dark (seg=0 while their anodes are on).
- Rolling/overflow: push "0","1","2","3","4" (7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011).
  - Next frame shows digit0=7'b0110011, digit1=7'b1111001, digit2=7'b1101101, digit3=7'b0110000; "0" is discarded.
- Clear vs. write: assert clear and in_valid with 7'b1111111 in the same cycle.
  - in_ready=0 that cycle, no transfer, fill=0 afterwards.
  - All digits dark on the next frame.
  - The scan timing (frame_start spacing of 32) is undisturbed.
- Reset mid-operation: fill=3, then assert rst for 1 cycle at div=5, idx=2.
  - Next cycle: an=0, seg=0, in_ready=0.
  - frame_start on the first post-reset cycle; the buffer reads dark.
- Polarity: rebuild with SEG_ACTIVE_LOW=1, push 7'b1111110 → lit seg=7'b0000001; blank and unfilled seg=7'b1111111; an is unchanged.
